// File: rtl/alu_packet_engine_if.sv
// alu_packet_engine_if: rx/tx byte-stream handshakes plus status between the UART side and the engine
interface alu_packet_engine_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       err;
  modport master (output rx_data, rx_valid, tx_ready, input rx_ready, tx_data, tx_valid, busy, err);
  modport slave (input rx_data, rx_valid, tx_ready, output rx_ready, tx_data, tx_valid, busy, err);
endinterface

// File: rtl/alu_packet_engine.sv
// alu_packet_engine: parses opcode/length/operand packets, folds operands left-to-right, streams the result LSB-first
module alu_packet_engine #(
  parameter int DATA_W = 32,
  parameter int LEN_W = 16
) (
  input logic clk_i,
  input logic rst_ni,
  alu_packet_engine_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int BW = NB > 1 ? $clog2(NB) : 1;
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [2:0] {OPC, RSV, LEN_LO, LEN_HI, DATA, DIV, TX} state_t;
  state_t state, state_nxt;
  logic [7:0] opc;
  logic [LEN_W-1:0] len, op_cnt;
  logic [BW-1:0] byte_cnt, tx_idx;
  logic [CW-1:0] div_cnt;
  logic [DATA_W-1:0] acc, opnd, opnd_nxt, dvs, rem, fold;
  logic [DATA_W:0] shifted, trial;
  logic rx_ready, tx_valid, busy, err;
  logic rx_ready_d, tx_valid_d, busy_d;
  logic rx_hs, tx_hs, last_byte, last_tx, first_op, last_op, known, is_div, rx_known;
  assign rx_hs = bus.rx_valid && rx_ready;
  assign tx_hs = tx_valid && bus.tx_ready;
  assign last_byte = byte_cnt == BW'(NB - 1);
  assign last_tx = tx_idx == BW'(NB - 1);
  assign first_op = op_cnt == '0;
  assign last_op = (LEN_W + 1)'(op_cnt) + 1'b1 == (LEN_W + 1)'(len);
  assign known = opc inside {[8'h10:8'h14]};
  assign rx_known = bus.rx_data inside {[8'h10:8'h14]};
  assign is_div = opc == 8'h12;
  assign opnd_nxt = (opnd >> 8) | (DATA_W'(bus.rx_data) << (DATA_W - 8));
  // acc doubles as the quotient register, so the dividend is shifted out as quotient bits shift in
  assign shifted = {rem, acc[DATA_W-1]};
  assign trial = shifted - {1'b0, dvs};
  always_comb begin
    fold = !known ? acc :
           first_op ? opnd_nxt :
           opc == 8'h10 ? acc + opnd_nxt :
           opc == 8'h11 ? acc * opnd_nxt :
           opc == 8'h13 ? acc - opnd_nxt :
           opc == 8'h14 ? (acc > opnd_nxt ? acc : opnd_nxt) : acc;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= OPC;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      OPC:     if (rx_hs) state_nxt = RSV;
      RSV:     if (rx_hs) state_nxt = LEN_LO;
      LEN_LO:  if (rx_hs) state_nxt = LEN_HI;
      LEN_HI:  if (rx_hs) state_nxt = {bus.rx_data, len[7:0]} != '0 ? DATA : TX;
      DATA:    if (rx_hs && last_byte) state_nxt = is_div && !first_op ? DIV : last_op ? TX : DATA;
      DIV:     if (div_cnt == CW'(DATA_W - 1)) state_nxt = op_cnt == len ? TX : DATA;
      TX:      if (tx_hs && last_tx) state_nxt = OPC;
      default: state_nxt = OPC;
    endcase
  end
  always_comb begin
    rx_ready_d = state_nxt inside {OPC, RSV, LEN_LO, LEN_HI, DATA};
    tx_valid_d = state_nxt == TX;
    busy_d = state_nxt != OPC;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_ready <= 1'b0;
      tx_valid <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
      opc <= '0;
      len <= '0;
      op_cnt <= '0;
      byte_cnt <= '0;
      tx_idx <= '0;
      div_cnt <= '0;
      acc <= '0;
      opnd <= '0;
      dvs <= '0;
      rem <= '0;
    end else begin
      rx_ready <= rx_ready_d;
      tx_valid <= tx_valid_d;
      busy <= busy_d;
      if (state == OPC && rx_hs) begin
        opc <= bus.rx_data;
        acc <= rx_known ? '0 : '1;
        err <= !rx_known;
        op_cnt <= '0;
        byte_cnt <= '0;
        tx_idx <= '0;
      end
      if (state == LEN_LO && rx_hs) len[7:0] <= bus.rx_data;
      if (state == LEN_HI && rx_hs) len[15:8] <= bus.rx_data;
      if (state == DATA && rx_hs) begin
        opnd <= opnd_nxt;
        byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
        if (last_byte) begin
          op_cnt <= op_cnt + 1'b1;
          if (is_div && !first_op) begin
            dvs <= opnd_nxt;
            rem <= '0;
            div_cnt <= '0;
            err <= err | (opnd_nxt == '0);
          end else acc <= fold;
        end
      end
      // restoring step; a zero divisor always subtracts, leaving an all-ones quotient
      if (state == DIV) begin
        div_cnt <= div_cnt + 1'b1;
        rem <= trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
        acc <= {acc[DATA_W-2:0], !trial[DATA_W]};
      end
      if (state == TX && tx_hs) tx_idx <= last_tx ? '0 : tx_idx + 1'b1;
    end
  end
  assign bus.rx_ready = rx_ready;
  assign bus.tx_valid = tx_valid;
  assign bus.tx_data = 8'(acc >> {tx_idx, 3'b000});
  assign bus.busy = busy;
  assign bus.err = err;
endmodule

// File: tb/tb_alu_packet_engine.sv
// tb_alu_packet_engine: scenario tasks against 32- and 16-bit engines with a plain-arithmetic fold model
module tb_alu_packet_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  alu_packet_engine_if b32();
  alu_packet_engine_if b16();
  alu_packet_engine #(.DATA_W(32), .LEN_W(16)) dut32 (.clk_i(clk), .rst_ni(rst_n), .bus(b32.slave));
  alu_packet_engine #(.DATA_W(16), .LEN_W(16)) dut16 (.clk_i(clk), .rst_ni(rst_n), .bus(b16.slave));

  function automatic logic rx_rdy(input int s);
    return s == 16 ? b16.rx_ready : b32.rx_ready;
  endfunction
  function automatic logic tx_v(input int s);
    return s == 16 ? b16.tx_valid : b32.tx_valid;
  endfunction
  function automatic logic [7:0] tx_d(input int s);
    return s == 16 ? b16.tx_data : b32.tx_data;
  endfunction
  function automatic logic err_of(input int s);
    return s == 16 ? b16.err : b32.err;
  endfunction
  task automatic drive_rx(input int s, input logic v, input logic [7:0] d);
    if (s == 16) begin b16.rx_valid = v; b16.rx_data = d; end
    else begin b32.rx_valid = v; b32.rx_data = d; end
  endtask
  task automatic set_txr(input int s, input logic r);
    if (s == 16) b16.tx_ready = r;
    else b32.tx_ready = r;
  endtask

  // reference fold: plain modular arithmetic on 64-bit values masked to the operand width
  function automatic logic [63:0] model(input int w, input logic [7:0] opc, input logic [63:0] ops[$], output logic er);
    logic [63:0] m;
    logic [63:0] a;
    logic [63:0] o;
    m = w == 64 ? '1 : (64'd1 << w) - 64'd1;
    a = 0;
    er = 1'b0;
    if (opc < 8'h10 || opc > 8'h14) begin er = 1'b1; return m; end
    foreach (ops[k]) begin
      o = ops[k] & m;
      if (k == 0) a = o;
      else if (opc == 8'h10) a = (a + o) & m;
      else if (opc == 8'h11) a = (a * o) & m;
      else if (opc == 8'h12) begin
        if (o == 0) begin a = m; er = 1'b1; end
        else a = a / o;
      end
      else if (opc == 8'h13) a = (a - o) & m;
      else a = a > o ? a : o;
    end
    return a;
  endfunction

  task automatic send_byte(input int s, input logic [7:0] d);
    int t;
    t = 0;
    drive_rx(s, 1'b1, d);
    @(negedge clk);
    while (!rx_rdy(s) && t < 300) begin t++; @(negedge clk); end
    if (!rx_rdy(s)) begin
      n_chk++; n_fail++;
      $display("FAIL rx_timeout: rx_ready=%b after %0d cycles, required 1", rx_rdy(s), t);
    end
    @(posedge clk); #1;
    drive_rx(s, 1'b0, 8'h00);
  endtask
  task automatic send_hdr(input int s, input logic [7:0] opc, input logic [15:0] n);
    send_byte(s, opc);
    send_byte(s, 8'($urandom));
    send_byte(s, n[7:0]);
    send_byte(s, n[15:8]);
  endtask
  task automatic send_ops(input int s, input logic [63:0] ops[$]);
    foreach (ops[k]) for (int b = 0; b < s / 8; b++) send_byte(s, 8'(ops[k] >> (8 * b)));
  endtask
  // collects one response; mode 1 asserts tx_ready one cycle in three and checks the stalled byte holds
  task automatic recv(input int s, input int mode, output logic [63:0] got);
    int k;
    int cyc;
    logic pend;
    logic r;
    logic [7:0] held;
    k = 0; cyc = 0; pend = 1'b0; held = 8'h00; got = 0;
    while (k < s / 8 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      r = mode == 0 ? 1'b1 : (cyc % 3 == 0);
      set_txr(s, r);
      if (pend) begin
        n_chk++;
        if (tx_v(s) !== 1'b1 || tx_d(s) !== held) begin
          n_fail++;
          $display("FAIL tx_hold: valid=%b data=%h, required valid=1 data=%h", tx_v(s), tx_d(s), held);
        end
      end
      pend = 1'b0;
      if (tx_v(s) === 1'b1) begin
        if (r) begin got = got | (64'(tx_d(s)) << (8 * k)); k++; end
        else begin pend = 1'b1; held = tx_d(s); end
      end
    end
    @(posedge clk); #1;
    set_txr(s, 1'b0);
    if (k < s / 8) begin
      n_chk++; n_fail++;
      $display("FAIL tx_timeout: got %0d bytes, required %0d", k, s / 8);
    end
  endtask
  task automatic run_pkt(input int s, input logic [7:0] opc, input logic [63:0] ops[$], input int mode, output logic [63:0] got, output logic er);
    send_hdr(s, opc, 16'(ops.size()));
    send_ops(s, ops);
    recv(s, mode, got);
    er = err_of(s);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk += 5;
    if (b32.rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 0", b32.rx_ready); end
    if (b32.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", b32.tx_valid); end
    if (b32.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", b32.tx_data); end
    if (b32.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", b32.busy); end
    if (b32.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", b32.err); end
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (b32.rx_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b want 0", b32.rx_ready); end
    @(posedge clk); #1;
    n_chk += 2;
    if (b32.rx_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge32: got %b want 1", b32.rx_ready); end
    if (b16.rx_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge16: got %b want 1", b16.rx_ready); end
  endtask

  task automatic test_add();
    logic [63:0] q[$];
    logic [63:0] got;
    q = '{64'd1, 64'd2};
    send_hdr(32, 8'h10, 16'd2);
    send_ops(32, q);
    @(negedge clk);
    n_chk += 3;
    if (b32.tx_valid !== 1'b1) begin n_fail++; $display("FAIL add_latency: tx_valid=%b want 1", b32.tx_valid); end
    if (b32.tx_data !== 8'h03) begin n_fail++; $display("FAIL add_byte0: got %h want 03", b32.tx_data); end
    if (b32.busy !== 1'b1) begin n_fail++; $display("FAIL add_busy_tx: got %b want 1", b32.busy); end
    recv(32, 0, got);
    n_chk += 3;
    if (got !== 64'h3) begin n_fail++; $display("FAIL add_result: got %h want 3", got); end
    if (b32.err !== 1'b0) begin n_fail++; $display("FAIL add_err: got %b want 0", b32.err); end
    if (b32.busy !== 1'b0) begin n_fail++; $display("FAIL add_busy_done: got %b want 0", b32.busy); end
  endtask

  task automatic test_mul_sub();
    logic [63:0] got;
    logic er;
    run_pkt(32, 8'h11, '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5}, 0, got, er);
    n_chk++;
    if (got !== 64'd120) begin n_fail++; $display("FAIL mul_result: got %h want 78", got); end
    run_pkt(32, 8'h13, '{64'd10, 64'd3, 64'd9}, 0, got, er);
    n_chk += 2;
    if (got !== 64'hFFFF_FFFE) begin n_fail++; $display("FAIL sub_result: got %h want fffffffe", got); end
    if (er !== 1'b0) begin n_fail++; $display("FAIL sub_err: got %b want 0", er); end
  endtask

  task automatic test_div();
    logic [63:0] got;
    logic er;
    int cnt;
    send_hdr(32, 8'h12, 16'd2);
    send_ops(32, '{64'd64, 64'd8});
    cnt = 0;
    @(negedge clk);
    n_chk++;
    if (b32.rx_ready !== 1'b0) begin n_fail++; $display("FAIL div_rx_stall: rx_ready=%b want 0", b32.rx_ready); end
    while (b32.tx_valid !== 1'b1 && cnt < 100) begin
      n_chk++;
      if (b32.rx_ready !== 1'b0) begin n_fail++; $display("FAIL div_rx_stall_cycle%0d: rx_ready=%b want 0", cnt, b32.rx_ready); end
      cnt++;
      @(negedge clk);
    end
    n_chk++;
    if (cnt != 32) begin n_fail++; $display("FAIL div_latency: %0d stall cycles, want 32", cnt); end
    recv(32, 0, got);
    n_chk += 2;
    if (got !== 64'd8) begin n_fail++; $display("FAIL div_result: got %h want 8", got); end
    if (b32.err !== 1'b0) begin n_fail++; $display("FAIL div_err: got %b want 0", b32.err); end
    run_pkt(32, 8'h12, '{64'd4, 64'd0}, 0, got, er);
    n_chk += 2;
    if (got !== 64'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_result: got %h want ffffffff", got); end
    if (er !== 1'b1) begin n_fail++; $display("FAIL div0_err: got %b want 1", er); end
    send_byte(32, 8'h10);
    n_chk++;
    if (b32.err !== 1'b0) begin n_fail++; $display("FAIL div0_err_clear: got %b want 0", b32.err); end
    send_byte(32, 8'h00);
    send_byte(32, 8'h00);
    send_byte(32, 8'h00);
    recv(32, 0, got);
    n_chk++;
    if (got !== 64'd0) begin n_fail++; $display("FAIL n0_result32: got %h want 0", got); end
  endtask

  task automatic test_backpressure();
    logic [63:0] got;
    logic er;
    run_pkt(32, 8'h14, '{64'd7, 64'd300, 64'd5}, 1, got, er);
    n_chk++;
    if (got !== 64'h12C) begin n_fail++; $display("FAIL max_bp_result: got %h want 12c", got); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] got;
    logic er;
    send_hdr(32, 8'h11, 16'd3);
    send_byte(32, 8'hAA);
    send_byte(32, 8'hBB);
    #2 rst_n = 1'b0;
    #1;
    n_chk += 2;
    if (b32.rx_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_rx_ready: got %b want 0", b32.rx_ready); end
    if (b32.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", b32.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_pkt(32, 8'h10, '{64'd3, 64'd4}, 0, got, er);
    n_chk += 2;
    if (got !== 64'd7) begin n_fail++; $display("FAIL midrst_result: got %h want 7", got); end
    if (er !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b want 0", er); end
  endtask

  task automatic test_unknown();
    logic [63:0] got;
    logic er;
    run_pkt(32, 8'h55, '{64'($urandom)}, 0, got, er);
    n_chk += 2;
    if (got !== 64'hFFFF_FFFF) begin n_fail++; $display("FAIL unknown_result: got %h want ffffffff", got); end
    if (er !== 1'b1) begin n_fail++; $display("FAIL unknown_err: got %b want 1", er); end
  endtask

  task automatic test_w16();
    logic [63:0] got;
    logic [63:0] exp;
    logic [63:0] q[$];
    logic er;
    logic eer;
    run_pkt(16, 8'h11, '{64'h100, 64'h100}, 0, got, er);
    n_chk++;
    if (got !== 64'h0) begin n_fail++; $display("FAIL w16_mul_result: got %h want 0", got); end
    send_hdr(16, 8'h10, 16'd0);
    @(negedge clk);
    n_chk++;
    if (b16.tx_valid !== 1'b1) begin n_fail++; $display("FAIL w16_n0_latency: tx_valid=%b want 1", b16.tx_valid); end
    recv(16, 0, got);
    n_chk++;
    if (got !== 64'h0) begin n_fail++; $display("FAIL w16_n0_result: got %h want 0", got); end
    for (int i = 0; i < 300; i++) q.push_back(64'($urandom));
    exp = model(16, 8'h10, q, eer);
    run_pkt(16, 8'h10, q, 0, got, er);
    n_chk++;
    if (got !== exp) begin n_fail++; $display("FAIL w16_long_result: got %h want %h", got, exp); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] q[$];
    logic [63:0] got;
    logic [63:0] exp;
    logic er;
    logic eer;
    int s;
    int r;
    logic [7:0] opc;
    for (int p = 0; p < 24; p++) begin
      s = $urandom_range(0, 1) == 1 ? 16 : 32;
      r = int'($urandom_range(0, 5));
      opc = r == 5 ? 8'h7F : 8'(8'h10 + r);
      q.delete();
      for (int i = 0; i < int'($urandom_range(0, 4)); i++)
        q.push_back(opc == 8'h12 && $urandom_range(0, 2) == 0 ? 64'($urandom_range(0, 4)) : 64'($urandom));
      exp = model(s, opc, q, eer);
      run_pkt(s, opc, q, int'($urandom_range(0, 1)), got, er);
      n_chk += 2;
      if (got !== exp) begin n_fail++; $display("FAIL rand%0d_result: w=%0d opc=%h n=%0d got %h want %h", p, s, opc, q.size(), got, exp); end
      if (er !== eer) begin n_fail++; $display("FAIL rand%0d_err: w=%0d opc=%h got %b want %b", p, s, opc, er, eer); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    b32.rx_valid = 1'b0; b32.rx_data = 8'h00; b32.tx_ready = 1'b0;
    b16.rx_valid = 1'b0; b16.rx_data = 8'h00; b16.tx_ready = 1'b0;
    test_reset();
    test_add();
    test_mul_sub();
    test_div();
    test_backpressure();
    test_reset_mid();
    test_unknown();
    test_w16();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
